mem_stage: RTL and testbench

//  Memory-access stage plus MEM/WB pipeline register; feeds the writeback unit directly.

---
 rtl/mem_stage_pkg.sv | 36 +++
 rtl/mem_stage_if.sv | 18 +
 rtl/mem_stage_lsu_align.sv | 54 +++++
 rtl/mem_stage.sv | 166 ++++++++++++++++
 tb/tb_mem_stage.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: writeback-select and funct3 encodings, FSM states and the alignment helper
// shared by the memory stage. Rev 1.0
`default_nettype none

package mem_stage_pkg;

  localparam logic [2:0] WB_NONE        = 3'b000;
  localparam logic [2:0] WB_DATAMEM     = 3'b001;
  localparam logic [2:0] WB_RESULT      = 3'b010;
  localparam logic [2:0] WB_CSR_DATAOUT = 3'b011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // funct3[1:0] carries the access size for both signed and unsigned loads
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = off[0];
      2'b10:   mis = (off != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory request/response bus between the memory stage (master)
// and the data memory (slave). Rev 1.0
`default_nettype none

interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, we, addr, wstrb, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wstrb, wdata, output ready, rdata);
endinterface

`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: combinational store lane strobe/replication and load byte/half extraction
// with sign or zero extension. Rev 1.0
`default_nettype none

module lsu_align
  import mem_stage_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] store_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    wstrb = 4'b1111;
    wdata = store_data;
    case (st_funct3[1:0])
      2'b00: begin
        wstrb = 4'b0001 << st_off;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        wstrb = 4'b0011 << st_off;
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        wstrb = 4'b1111;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    shifted   = rdata >> {ld_off, 3'b000};
    load_data = shifted;
    case (ld_funct3)
      F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_data = {24'h0, shifted[7:0]};
      F3_HU:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage with MEM/WB register; issues byte-strobed data-memory
// requests, stalls upstream while memory is busy, aborts on timeout. Rev 1.0
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [2:0]  ex_wb_src,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_csr_dataout,
  output logic        mem_stall,
  mem_stage_if.master dmem,
  output logic [2:0]  wb_src,
  output logic [4:0]  rd,
  output logic [31:0] result,
  output logic [31:0] csr_dataout,
  output logic [31:0] dmem_dataout,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    wstrb_q;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [1:0]    off_q;

  logic [3:0]    st_wstrb;
  logic [31:0]   st_wdata, ld_data;
  logic          is_mem, misal, timeout_hit, accept, misal_next, berr_next;
  logic [2:0]    wb_src_next;
  logic [31:0]   dataout_next;

  assign is_mem      = ex_valid && (ex_mem_read || ex_mem_write);
  assign misal       = is_mem && is_misaligned(ex_funct3, ex_result[1:0]);
  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CNT_LAST);

  lsu_align u_align (
    .st_funct3  (ex_funct3),
    .st_off     (ex_result[1:0]),
    .store_data (ex_store_data),
    .ld_funct3  (funct3_q),
    .ld_off     (off_q),
    .rdata      (dmem.rdata),
    .wstrb      (st_wstrb),
    .wdata      (st_wdata),
    .load_data  (ld_data)
  );

  assign dmem.req   = (state == ST_WAIT);
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wstrb = wstrb_q;
  assign dmem.wdata = wdata_q;

  // MEM/WB loads every cycle; anything that is not a retiring instruction becomes a bubble
  always_comb begin
    state_next   = state;
    mem_stall    = 1'b0;
    accept       = 1'b0;
    wb_src_next  = WB_NONE;
    dataout_next = '0;
    misal_next   = 1'b0;
    berr_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (misal) begin
          misal_next = 1'b1;
        end else if (is_mem) begin
          mem_stall  = 1'b1;
          accept     = 1'b1;
          state_next = ST_WAIT;
        end else if (ex_valid) begin
          wb_src_next = ex_wb_src;
        end
      end
      ST_WAIT: begin
        if (dmem.ready) begin
          state_next   = ST_IDLE;
          wb_src_next  = we_q ? WB_NONE : ex_wb_src;
          dataout_next = we_q ? 32'h0 : ld_data;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
          berr_next  = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ST_WAIT && !dmem.ready && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      off_q    <= '0;
    end else if (accept) begin
      addr_q   <= {ex_result[31:2], 2'b00};
      wdata_q  <= st_wdata;
      wstrb_q  <= st_wstrb;
      we_q     <= ex_mem_write;
      funct3_q <= ex_funct3;
      off_q    <= ex_result[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_src       <= WB_NONE;
      rd           <= '0;
      result       <= '0;
      csr_dataout  <= '0;
      dmem_dataout <= '0;
      misalign     <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      wb_src       <= wb_src_next;
      rd           <= ex_rd;
      result       <= ex_result;
      csr_dataout  <= ex_csr_dataout;
      dmem_dataout <= dataout_next;
      misalign     <= misal_next;
      bus_err      <= berr_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage; expected writeback records are queued at
// issue and popped by a monitor one cycle after each instruction leaves the stage.
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  typedef struct {
    string       name;
    logic [2:0]  wb;
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] csr;
    logic [31:0] data;
    bit          chk_data;
    bit          chk_full;
    bit          mis;
    bit          berr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3, ex_wb_src;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result, ex_store_data, ex_csr_dataout;
  logic        mem_stall;
  logic [2:0]  wb_src;
  logic [4:0]  rd;
  logic [31:0] result, csr_dataout, dmem_dataout;
  logic        misalign, bus_err;

  mem_stage_if dmem_bus ();

  mem_stage #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_mem_read    (ex_mem_read),
    .ex_mem_write   (ex_mem_write),
    .ex_funct3      (ex_funct3),
    .ex_wb_src      (ex_wb_src),
    .ex_rd          (ex_rd),
    .ex_result      (ex_result),
    .ex_store_data  (ex_store_data),
    .ex_csr_dataout (ex_csr_dataout),
    .mem_stall      (mem_stall),
    .dmem           (dmem_bus),
    .wb_src         (wb_src),
    .rd             (rd),
    .result         (result),
    .csr_dataout    (csr_dataout),
    .dmem_dataout   (dmem_dataout),
    .misalign       (misalign),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  bit   pending = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [2:0] wb, input logic [4:0] r,
                              input logic [31:0] res, input logic [31:0] csr,
                              input logic [31:0] data, input bit cd, input bit cf,
                              input bit mis, input bit be);
    exp_t e;
    e.name = nm; e.wb = wb; e.rd = r; e.res = res; e.csr = csr; e.data = data;
    e.chk_data = cd; e.chk_full = cf; e.mis = mis; e.berr = be;
    return e;
  endfunction

  // Monitor: an instruction leaving the stage at an edge shows on the MEM/WB outputs after it
  initial begin
    forever begin
      @(negedge clk);
      if (pending) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL retire: got retirement, expected none queued");
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, ".wb_src"}, 32'(wb_src), 32'(mon_e.wb));
          check({mon_e.name, ".misalign"}, 32'(misalign), 32'(mon_e.mis));
          check({mon_e.name, ".bus_err"}, 32'(bus_err), 32'(mon_e.berr));
          if (mon_e.chk_full) begin
            check({mon_e.name, ".rd"}, 32'(rd), 32'(mon_e.rd));
            check({mon_e.name, ".result"}, result, mon_e.res);
            check({mon_e.name, ".csr"}, csr_dataout, mon_e.csr);
          end
          if (mon_e.chk_data) check({mon_e.name, ".dataout"}, dmem_dataout, mon_e.data);
        end
      end
      pending = rst_n && ex_valid && !mem_stall;
    end
  end

  task automatic issue_alu(input string nm, input logic [2:0] wbs, input logic [4:0] r,
                           input logic [31:0] res, input logic [31:0] csr);
    sb.push_back(mk(nm, wbs, r, res, csr, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0));
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = F3_W;
    ex_wb_src = wbs; ex_rd = r; ex_result = res; ex_csr_dataout = csr;
    #1;
    check({nm, ".stall"}, 32'(mem_stall), 32'd0);
    check({nm, ".req"}, 32'(dmem_bus.req), 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  // Starts at posedge+1; memory answers on request cycle 'delay' (-1 = never);
  // abort_at >= 0 pulls rst_n low on that request cycle instead.
  task automatic issue_mem(input string nm, input bit ld, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [2:0] wbs, input logic [31:0] rdata, input int delay,
                           input int abort_at, input int exp_stall, input int exp_req,
                           input exp_t e, input logic [3:0] x_wstrb, input logic [31:0] x_wdata);
    int  k = 0;
    int  stalls = 0;
    int  reqs = 0;
    bit  done = 1'b0;
    if (abort_at < 0) sb.push_back(e);
    ex_valid = 1'b1; ex_mem_read = ld; ex_mem_write = !ld; ex_funct3 = f3;
    ex_result = addr; ex_store_data = sdata; ex_wb_src = wbs; ex_rd = e.rd;
    ex_csr_dataout = e.csr;
    for (int guard = 0; guard < 40 && !done; guard++) begin
      dmem_bus.ready = 1'b0;
      if (dmem_bus.req) begin
        reqs++;
        if (k == 0) begin
          check({nm, ".addr"}, dmem_bus.addr, {addr[31:2], 2'b00});
          check({nm, ".we"}, 32'(dmem_bus.we), 32'(!ld));
          if (!ld) begin
            check({nm, ".wstrb"}, 32'(dmem_bus.wstrb), 32'(x_wstrb));
            check({nm, ".wdata"}, dmem_bus.wdata, x_wdata);
          end
        end
        if (abort_at >= 0 && k == abort_at) begin
          rst_n = 1'b0;
          @(posedge clk); #1;
          rst_n = 1'b1; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
          #1;
          check({nm, ".rst_req"}, 32'(dmem_bus.req), 32'd0);
          check({nm, ".rst_wb"}, 32'(wb_src), 32'(WB_NONE));
          check({nm, ".rst_stall"}, 32'(mem_stall), 32'd0);
          return;
        end
        if (k == delay) begin
          dmem_bus.ready = 1'b1;
          dmem_bus.rdata = rdata;
        end
        k++;
      end
      #1;
      if (mem_stall) stalls++;
      else done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s.done: got still stalled after 40 cycles, expected release", nm);
    end
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; dmem_bus.ready = 1'b0;
    check({nm, ".stall_cycles"}, 32'(stalls), 32'(exp_stall));
    check({nm, ".req_cycles"}, 32'(reqs), 32'(exp_req));
  endtask

  task automatic stray_ready(input string nm);
    dmem_bus.ready = 1'b1;
    dmem_bus.rdata = 32'hBAD0_BAD0;
    #1;
    check({nm, ".req"}, 32'(dmem_bus.req), 32'd0);
    check({nm, ".stall"}, 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dmem_bus.ready = 1'b0;
    #1;
    check({nm, ".wb"}, 32'(wb_src), 32'(WB_NONE));
    check({nm, ".dataout"}, dmem_dataout, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
    ex_wb_src = '0; ex_rd = '0; ex_result = '0; ex_store_data = '0; ex_csr_dataout = '0;
    dmem_bus.ready = 1'b0; dmem_bus.rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset.wb", 32'(wb_src), 32'(WB_NONE));
    check("reset.rd", 32'(rd), 32'd0);
    check("reset.result", result, 32'h0);
    check("reset.dataout", dmem_dataout, 32'h0);
    check("reset.req", 32'(dmem_bus.req), 32'd0);
    check("reset.stall", 32'(mem_stall), 32'd0);
    check("reset.misalign", 32'(misalign), 32'd0);
    check("reset.bus_err", 32'(bus_err), 32'd0);
    @(posedge clk); #1;

    issue_alu("alu", WB_RESULT, 5'd5, 32'h0000_1234, 32'h0);
    issue_alu("csr", WB_CSR_DATAOUT, 5'd9, 32'h0000_0040, 32'hDEAD_BEEF);

    issue_mem("lb", 1'b1, F3_B, 32'h103, 32'h0, WB_DATAMEM, 32'h80FF_0000, 3, -1, 4, 4,
              mk("lb", WB_DATAMEM, 5'd7, 32'h103, 32'h0, 32'hFFFF_FF80, 1, 1, 0, 0),
              4'h0, 32'h0);
    issue_mem("sh", 1'b0, F3_H, 32'h202, 32'h0000_ABCD, WB_RESULT, 32'h0, 0, -1, 1, 1,
              mk("sh", WB_NONE, 5'd0, 32'h202, 32'h0, 32'h0, 0, 0, 0, 0),
              4'b1100, 32'hABCD_ABCD);
    issue_mem("sb", 1'b0, F3_B, 32'h201, 32'h1234_5678, WB_NONE, 32'h0, 1, -1, 2, 2,
              mk("sb", WB_NONE, 5'd0, 32'h201, 32'h0, 32'h0, 0, 0, 0, 0),
              4'b0010, 32'h7878_7878);
    issue_mem("sw", 1'b0, F3_W, 32'h2F0, 32'hCAFE_F00D, WB_NONE, 32'h0, 0, -1, 1, 1,
              mk("sw", WB_NONE, 5'd0, 32'h2F0, 32'h0, 32'h0, 0, 0, 0, 0),
              4'b1111, 32'hCAFE_F00D);
    issue_mem("lh", 1'b1, F3_H, 32'h102, 32'h0, WB_DATAMEM, 32'hFEDC_0000, 0, -1, 1, 1,
              mk("lh", WB_DATAMEM, 5'd3, 32'h102, 32'h0, 32'hFFFF_FEDC, 1, 1, 0, 0),
              4'h0, 32'h0);
    issue_mem("lbu", 1'b1, F3_BU, 32'h101, 32'h0, WB_DATAMEM, 32'h1122_3344, 0, -1, 1, 1,
              mk("lbu", WB_DATAMEM, 5'd4, 32'h101, 32'h0, 32'h0000_0033, 1, 1, 0, 0),
              4'h0, 32'h0);

    issue_mem("lw_mis", 1'b1, F3_W, 32'h6, 32'h0, WB_DATAMEM, 32'h0, 0, -1, 0, 0,
              mk("lw_mis", WB_NONE, 5'd1, 32'h6, 32'h0, 32'h0, 0, 0, 1, 0), 4'h0, 32'h0);
    issue_mem("sh_mis", 1'b0, F3_H, 32'h203, 32'h5555, WB_NONE, 32'h0, 0, -1, 0, 0,
              mk("sh_mis", WB_NONE, 5'd0, 32'h203, 32'h0, 32'h0, 0, 0, 1, 0), 4'h0, 32'h0);

    issue_mem("lw_tmo", 1'b1, F3_W, 32'h400, 32'h0, WB_DATAMEM, 32'h0, -1, -1, 4, 4,
              mk("lw_tmo", WB_NONE, 5'd2, 32'h400, 32'h0, 32'h0, 0, 0, 0, 1), 4'h0, 32'h0);
    stray_ready("tmo_late");

    issue_mem("lhu_rst", 1'b1, F3_HU, 32'h302, 32'h0, WB_DATAMEM, 32'h0, -1, 2, 0, 0,
              mk("lhu_rst", WB_NONE, 5'd6, 32'h302, 32'h0, 32'h0, 0, 0, 0, 0), 4'h0, 32'h0);
    stray_ready("rst_late");

    issue_mem("lhu", 1'b1, F3_HU, 32'h302, 32'h0, WB_DATAMEM, 32'h8001_0000, 1, -1, 2, 2,
              mk("lhu", WB_DATAMEM, 5'd6, 32'h302, 32'h0, 32'h0000_8001, 1, 1, 0, 0),
              4'h0, 32'h0);
    issue_mem("lw", 1'b1, F3_W, 32'h10, 32'h0, WB_DATAMEM, 32'h1122_3344, 0, -1, 1, 1,
              mk("lw", WB_DATAMEM, 5'd8, 32'h10, 32'h0, 32'h1122_3344, 1, 1, 0, 0),
              4'h0, 32'h0);
    issue_alu("alu2", WB_RESULT, 5'd31, 32'hFFFF_0001, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard.empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
